// File: rtl/V1_parameter.sv
// rtl/V1_parameter.sv - shared widths, defaults and output-stage states for mac_accum
package V1_parameter;

   localparam int S_DEF     = 8;
   localparam int N_ACC_DEF = 4;

   // Exact sum width: N_ACC samples of 2*S bits never overflow this many bits.
   function automatic int acc_width(input int s, input int n_acc);
      return 2 * s + $clog2(n_acc);
   endfunction

   localparam int ACC_W_DEF = acc_width(S_DEF, N_ACC_DEF);

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/mac_accum.sv
// rtl/mac_accum.sv - frame accumulator summing N_ACC unsigned samples with a one-entry output register
module mac_accum
   import V1_parameter::*;
#(
   parameter  int S     = S_DEF,
   parameter  int N_ACC = N_ACC_DEF,
   localparam int ACC_W = acc_width(S, N_ACC),
   localparam int CW    = $clog2(N_ACC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [2*S-1:0]   in_data,
   output logic             in_ready,
   input  logic             clear,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_sum,
   input  logic             out_ready,
   output logic [CW-1:0]    frame_cnt
);

   localparam logic [CW-1:0] LAST_CNT = CW'(N_ACC - 1);

   out_state_t       state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum_next;
   logic             last_slot;
   logic             accept;
   logic             complete;
   logic             pop;

   assign last_slot = (frame_cnt == LAST_CNT);
   assign out_valid = (state == OUT_FULL);

   // Only the completing sample needs the output register, so only it is held back.
   assign in_ready  = !out_valid || out_ready || !last_slot;
   assign accept    = in_valid && in_ready && !clear;
   assign complete  = accept && last_slot;
   assign pop       = out_valid && out_ready;
   assign sum_next  = acc + ACC_W'(in_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc       <= '0;
         frame_cnt <= '0;
      end else if (clear) begin
         acc       <= '0;
         frame_cnt <= '0;
      end else if (accept) begin
         if (last_slot) begin
            acc       <= '0;
            frame_cnt <= '0;
         end else begin
            acc       <= sum_next;
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   // A completion in the same cycle as a pop refills the register without a bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= OUT_EMPTY;
         out_sum <= '0;
      end else begin
         if (complete) begin
            out_sum <= sum_next;
         end
         case (state)
            OUT_EMPTY: if (complete)         state <= OUT_FULL;
            OUT_FULL:  if (pop && !complete) state <= OUT_EMPTY;
            default:                         state <= OUT_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_accum.sv
// tb/tb_mac_accum.sv - directed and random checks of mac_accum against a frame-level model
module tb_mac_accum;

   localparam int S     = 8;
   localparam int N     = 4;
   localparam int ACC_W = 18;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic [2*S-1:0]   in_data = '0;
   logic             in_ready;
   logic             clear = 1'b0;
   logic             out_valid;
   logic [ACC_W-1:0] out_sum;
   logic             out_ready = 1'b0;
   logic [1:0]       frame_cnt;

   int tests = 0;
   int fails = 0;

   // Model: samples of the open frame, plus the held output word.
   int unsigned frame_q[$];
   bit          m_valid;
   int unsigned m_sum;
   int unsigned popped[$];

   mac_accum #(.S(S), .N_ACC(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .clear     (clear),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .out_ready (out_ready),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_ready(input bit ordy);
      return !m_valid || ordy || (frame_q.size() != N - 1);
   endfunction

   task automatic model_reset();
      frame_q.delete();
      m_valid = 1'b0;
      m_sum   = 0;
   endtask

   // One clock of stimulus; the model advances from the frame rules and all outputs are compared.
   task automatic step(input bit v, input int unsigned d, input bit clr, input bit ordy);
      bit          rdy;
      bit          done;
      int unsigned total;
      in_valid  = v;
      in_data   = d[2*S-1:0];
      clear     = clr;
      out_ready = ordy;
      #1;
      rdy = model_ready(ordy);
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      done = 1'b0;
      if (m_valid && ordy) popped.push_back(m_sum);
      if (clr) begin
         frame_q.delete();
      end else if (v && rdy) begin
         frame_q.push_back(d & 32'hFFFF);
         if (frame_q.size() == N) begin
            total = 0;
            foreach (frame_q[i]) total += frame_q[i];
            m_sum = total;
            done  = 1'b1;
            frame_q.delete();
         end
      end
      if (done)                m_valid = 1'b1;
      else if (m_valid && ordy) m_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("out_sum", {14'd0, out_sum}, m_sum);
      chk("frame_cnt", {30'd0, frame_cnt}, frame_q.size());
   endtask

   task automatic reset_pulse();
      reset = 1'b0;
      #1;
      model_reset();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_sum", {14'd0, out_sum}, 32'd0);
      chk("rst_frame_cnt", {30'd0, frame_cnt}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int unsigned vals[4];
      model_reset();
      in_valid = 1'b0;
      out_ready = 1'b0;
      #2;
      reset_pulse();

      // Basic frame
      vals = '{100, 200, 300, 400};
      foreach (vals[i]) step(1, vals[i], 0, 1);
      chk("basic_sum", {14'd0, out_sum}, 32'd1000);
      chk("basic_valid", {31'd0, out_valid}, 32'd1);
      step(0, 0, 0, 1);
      chk("basic_valid_drop", {31'd0, out_valid}, 32'd0);

      // Max values
      for (int i = 0; i < 4; i++) step(1, 65535, 0, 1);
      chk("max_sum", {14'd0, out_sum}, 32'd262140);
      step(0, 0, 0, 1);

      // Backpressure: 7 accepted, 8th blocked, then simultaneous pop and completion
      popped.delete();
      for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
      chk("bp_held_sum", {14'd0, out_sum}, 32'd4);
      chk("bp_cnt", {30'd0, frame_cnt}, 32'd3);
      in_valid = 1'b1; in_data = 16'd1; out_ready = 1'b0;
      #1;
      chk("bp_blocked", {31'd0, in_ready}, 32'd0);
      step(1, 1, 0, 1);
      chk("simul_valid", {31'd0, out_valid}, 32'd1);
      chk("simul_sum", {14'd0, out_sum}, 32'd4);
      step(0, 0, 0, 1);
      chk("bp_pop_count", popped.size(), 32'd2);
      if (popped.size() == 2) chk("bp_second_pop", popped[1], 32'd4);

      // Simultaneous with a different sum
      for (int i = 0; i < 4; i++) step(1, 3, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 9, 0, 0);
      step(1, 9, 0, 1);
      chk("simul2_sum", {14'd0, out_sum}, 32'd36);
      step(0, 0, 0, 1);

      // Clear drops the partial frame and the sample offered with it
      step(1, 5, 0, 1);
      step(1, 6, 0, 1);
      step(1, 7, 1, 1);
      chk("clear_cnt", {30'd0, frame_cnt}, 32'd0);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
      chk("clear_sum", {14'd0, out_sum}, 32'd4);
      step(0, 0, 0, 1);

      // Reset mid-frame with a held sum
      for (int i = 0; i < 4; i++) step(1, 50, 0, 0);
      step(1, 2, 0, 0);
      step(1, 2, 0, 0);
      in_valid = 1'b0;
      reset_pulse();
      for (int i = 0; i < 4; i++) step(1, 10, 0, 1);
      chk("reset_sum", {14'd0, out_sum}, 32'd40);
      step(0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
